// File: rtl/mac_ex_sequencer.sv
// Multi-cycle EX-stage sequencer for MAC-type instructions.
// Runs a fixed-latency shift-add multiply into a private accumulator.
module mac_ex_sequencer #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64
) (
    input  logic             Clk_In,
    input  logic             Reset_n_In,
    input  logic             Start_In,
    input  logic             Flush_In,
    input  logic [31:0]      Inst_In,
    input  logic [WIDTH-1:0] Operand_A_val_In,
    input  logic [WIDTH-1:0] Operand_B_val_In,
    output logic             Stall_Out,
    output logic             Done_Out,
    output logic [31:0]      Result_Out,
    output logic [31:0]      Inst_Out,
    output logic             Ovf_Out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] prod_q, prod_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [31:0]          res_q, res_d;
    logic [31:0]          inst_q, inst_d;
    logic [ACC_WIDTH:0]   sum;
    logic [2:0]           funct3;

    assign funct3 = Inst_In[14:12];
    // One extra bit catches the accumulator carry-out
    assign sum = {1'b0, acc_q} + {1'b0, prod_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        inst_d  = inst_q;
        case (state_q)
            S_IDLE: begin
                if (Start_In && !Flush_In) begin
                    inst_d  = Inst_In;
                    a_d     = Operand_A_val_In;
                    b_d     = Operand_B_val_In;
                    state_d = S_DONE;
                    case (funct3)
                        3'b000: begin
                            state_d = S_MUL;
                            prod_d  = '0;
                            cnt_d   = '0;
                        end
                        3'b001: begin
                            acc_d = '0;
                            ovf_d = 1'b0;
                            res_d = '0;
                        end
                        3'b010:  res_d = acc_q[31:0];
                        default: res_d = '0;
                    endcase
                end
            end
            S_MUL: begin
                if (Flush_In) begin
                    state_d = S_IDLE;
                end else begin
                    if (b_q[0])
                        prod_d = prod_q + (ACC_WIDTH'(a_q) << cnt_q);
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (Flush_In) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = sum[ACC_WIDTH-1:0];
                    res_d   = sum[31:0];
                    state_d = S_DONE;
                    if (sum[ACC_WIDTH])
                        ovf_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            inst_q  <= inst_d;
        end
    end

    assign Stall_Out  = ((state_q == S_IDLE) && Start_In && !Flush_In)
                      || (state_q == S_MUL) || (state_q == S_ACC);
    assign Done_Out   = (state_q == S_DONE);
    assign Result_Out = res_q;
    assign Inst_Out   = inst_q;
    assign Ovf_Out    = ovf_q;

endmodule
